star_mapper: RTL and testbench
==============================

# star_mapper

Measures the extent of a star found by the pixel-scan stage and erases it from the image RAM so the scan does not find it again. Sits directly downstream of the scanner FSM, started by its `goStarMap` level and answering with `doneStarMap`. The registered bounding box (x, y, width, height) is handed to the square-drawing stage. Stars are axis-aligned solid rectangles, and the start pixel is the star's top-left (first lit pixel in raster order).

## Interface
- `WIDTH`, 6: image width in pixels
- `HEIGHT`, 6: image height in pixels
- `THRESHOLD`, 0: a pixel is lit when `mem_q > THRESHOLD`
- `COL_SZ`, 3: pixel colour width
- `clk`  in  1: single clock; all state is updated on its rising edge
- `reset`  in  1: asynchronous, active-high reset
- `go`  in  1: start level from the scanner FSM, held until `done` is seen
- `x_in`, `y_in`  in  3 each: start (top-left) pixel coordinates
- `mem_addr`  out  6: RAM address, equal to y*WIDTH+x
- `mem_wren`  out  1: RAM write enable
- `mem_data`  out  COL_SZ: write data, constant 0 (black)
- `mem_q`  in  COL_SZ: RAM read data, valid 1 cycle after the address
- `busy`  out  1: high in every state except IDLE
- `done`  out  1: completion flag (doneStarMap)
- `box_x`, `box_y`  out  3 each: registered top-left corner
- `box_w`, `box_h`  out  3 each: registered width/height, range 1..6

## Operation
- States:
  - IDLE → LATCH when `go`=1.
  - LATCH: capture `x_in`/`y_in` into the box origin and set w=h=1.
    - If `x_in` ≥ WIDTH or `y_in` ≥ HEIGHT: set w=h=0 and go to DONE, with no RAM traffic.
  - LATCH → PROBE_X, or → PROBE_Y if x0 = WIDTH-1.
  - PROBE_X: drive `mem_addr` for (x0+w, y0) → CHK_X.
  - CHK_X: if `mem_q` is lit, w += 1.
    - Return to PROBE_X while lit and x0+w < WIDTH after the increment.
    - Otherwise go to PROBE_Y, or to BLOT if y0 = HEIGHT-1.
  - PROBE_Y / CHK_Y: same scheme down column x0 at (x0, y0+h), bounded by HEIGHT → BLOT.
  - BLOT: assert `mem_wren` at one rectangle pixel per cycle.
    - Order is raster: x0..x0+w-1 inner loop, y0..y0+h-1 outer loop.
    - Leave for DONE after the w*h-th write.
  - DONE: `done`=1, held until `go`=0, then → IDLE.
- The start pixel is never read; it is lit by contract.
- `go` falling before DONE is ignored; the operation runs to completion.
- `box_*` update only in LATCH/CHK states and hold their value from DONE until the next LATCH.
- All arithmetic is unsigned. The probe coordinate is computed at 4 bits so that x0+w = 6 does not wrap.

## Timing
- Reset values, applied asynchronously:
  - state IDLE
  - `busy`, `done`, `mem_wren` = 0
  - `mem_addr` = 0
  - all `box_*` = 0
- Reset mid-BLOT drops `mem_wren` immediately. The partial erase is not undone.
- `mem_addr`/`mem_wren` are registered outputs; `mem_q` is sampled in CHK exactly one cycle after the address was driven in PROBE.
- Cycle count from `go` sampled to `done`=1: 1 (LATCH) + 2×(x probes) + 2×(y probes) + w*h (BLOT).
  - x probes = w-1, plus 1 if the scan stopped on a dark pixel rather than the edge.
  - y probes follow the same rule for h.
- Handshake: `done` rises 1 cycle after the last write and falls the cycle after `go` is sampled low. A new `go` is accepted only from IDLE.

## Structure
- Shared package holds:
  - constants IMG_WIDTH=6, IMG_HEIGHT=6, PIX_THRESHOLD=0
  - the state encoding (4-bit localparams), shared with the scanner FSM for debug display
- One sub-module, `mapper_addr`: combinational (x,y) → y*WIDTH+x, implemented with shift-add for WIDTH=6 (y*4 + y*2 + x). It is instantiated once, fed by a mux of probe/blot coordinates.

## Test plan
- Start (2,1), lit 2×3 block at x 2–3, y 1–3, dark elsewhere → w=2, h=3. Writes go to addresses 8,9,14,15,20,21 in that order, and `done` follows in cycle 1+4+6+6=17.
- Start (5,0), lit column x=5, y 0–5 → no x probes, h=6 (stop on edge), 6 writes to addresses 5,11,17,23,29,35.
- Start (0,5), lit row y=5 → w=6, h=1, 6 writes to addresses 30–35, no y probes.
- Single lit pixel at (3,3) → w=h=1, one write to address 21, `done` at cycle 1+2+2+1=6.
- `go` held 3 cycles after `done` → `done` stays high for those 3 cycles. Once `go` falls, `done` clears the next cycle and `busy`=0.
- Assert `reset` during BLOT of the first scenario → `mem_wren`, `busy` and `done` drop in the same cycle and the state returns to IDLE. A fresh `go` restarts cleanly.

Source files
------------

// File: rtl/star_mapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : star_mapper_pkg
// Description : Shared constants and state encoding for the star mapper.
//               The state codes are also decoded by the scanner FSM's debug
//               display, so they must not be renumbered.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package star_mapper_pkg;

    localparam int IMG_WIDTH     = 6;
    localparam int IMG_HEIGHT    = 6;
    localparam int PIX_THRESHOLD = 0;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_LATCH   = 4'd1;
    localparam state_t S_PROBE_X = 4'd2;
    localparam state_t S_CHK_X   = 4'd3;
    localparam state_t S_PROBE_Y = 4'd4;
    localparam state_t S_CHK_Y   = 4'd5;
    localparam state_t S_BLOT    = 4'd6;
    localparam state_t S_DONE    = 4'd7;

endpackage
`default_nettype wire

// File: rtl/star_mapper_addr.sv
`default_nettype none
// ============================================================================
// Module      : mapper_addr
// Description : Pixel coordinate to linear RAM address, y*6 + x, built from
//               shifts and adds (y*4 + y*2 + x). Only valid for a 6-pixel-wide
//               image.
// Ports       : i_x    - pixel column (0..5)
//               i_y    - pixel row (0..5)
//               o_addr - linear RAM address (0..35)
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_addr (
    input  logic [2:0] i_x,
    input  logic [2:0] i_y,
    output logic [5:0] o_addr
);

    assign o_addr = {1'b0, i_y, 2'b00} + {2'b00, i_y, 1'b0} + {3'b000, i_x};

endmodule
`default_nettype wire

// File: rtl/star_mapper.sv
`default_nettype none
// ============================================================================
// Module      : star_mapper
// Description : Measures the bounding box of a solid rectangular star whose
//               top-left pixel is given, then erases it from the image RAM.
//               Width is found by probing right along the top row, height by
//               probing down the left column; the rectangle is then blotted
//               in raster order.
// Ports       : clk, reset       - clock, asynchronous active-high reset
//               go               - start level, held until done is seen
//               x_in, y_in       - start (top-left) pixel
//               mem_addr/wren/data/q - image RAM port (1-cycle read latency)
//               busy             - high whenever not idle
//               done             - completion flag, held until go drops
//               box_x/y/w/h      - registered bounding box
// Revision    : 1.0 - initial release
// ============================================================================
module star_mapper
    import star_mapper_pkg::*;
#(
    parameter int WIDTH     = IMG_WIDTH,
    parameter int HEIGHT    = IMG_HEIGHT,
    parameter int THRESHOLD = PIX_THRESHOLD,
    parameter int COL_SZ    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [2:0]        x_in,
    input  logic [2:0]        y_in,
    output logic [5:0]        mem_addr,
    output logic              mem_wren,
    output logic [COL_SZ-1:0] mem_data,
    input  logic [COL_SZ-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic [2:0]        box_x,
    output logic [2:0]        box_y,
    output logic [2:0]        box_w,
    output logic [2:0]        box_h
);

    // Bounds are compared at 4 bits so that x0+w = 6 does not wrap to 0.
    localparam logic [3:0] c_width_lim  = 4'(WIDTH);
    localparam logic [3:0] c_height_lim = 4'(HEIGHT);
    localparam logic [2:0] c_x_max      = 3'(WIDTH - 1);
    localparam logic [2:0] c_y_max      = 3'(HEIGHT - 1);

    state_t      state_q, state_d;
    logic [2:0]  box_x_q, box_x_d;
    logic [2:0]  box_y_q, box_y_d;
    logic [2:0]  box_w_q, box_w_d;
    logic [2:0]  box_h_q, box_h_d;
    logic [2:0]  bx_q, bx_d;          // blot pixel column
    logic [2:0]  by_q, by_d;          // blot pixel row
    logic [5:0]  mem_addr_q, mem_addr_d;
    logic        mem_wren_q, mem_wren_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        w_lit;
    logic        w_in_range;
    logic [3:0]  w_x_next;            // x0 + w after a lit probe
    logic [3:0]  w_y_next;            // y0 + h after a lit probe
    logic        w_row_end;
    logic        w_blot_last;
    logic [2:0]  w_addr_x;
    logic [2:0]  w_addr_y;
    logic [5:0]  w_addr;

    assign w_lit      = (mem_q > COL_SZ'(THRESHOLD));
    assign w_in_range = ({1'b0, x_in} < c_width_lim) && ({1'b0, y_in} < c_height_lim);
    assign w_x_next   = {1'b0, box_x_q} + {1'b0, box_w_q} + 4'd1;
    assign w_y_next   = {1'b0, box_y_q} + {1'b0, box_h_q} + 4'd1;
    // bx+1 == x0+w avoids the underflow of x0+w-1 when comparing the row end.
    assign w_row_end   = (({1'b0, bx_q} + 4'd1) == ({1'b0, box_x_q} + {1'b0, box_w_q}));
    assign w_blot_last = w_row_end &&
                         (({1'b0, by_q} + 4'd1) == ({1'b0, box_y_q} + {1'b0, box_h_q}));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_LATCH;
            end
            S_LATCH: begin
                if (!w_in_range)         state_d = S_DONE;
                else if (x_in != c_x_max) state_d = S_PROBE_X;
                else if (y_in != c_y_max) state_d = S_PROBE_Y;
                else                      state_d = S_BLOT;   // corner pixel: nothing to probe
            end
            S_PROBE_X: state_d = S_CHK_X;
            S_CHK_X: begin
                if (w_lit && (w_x_next < c_width_lim)) state_d = S_PROBE_X;
                else if (box_y_q != c_y_max)           state_d = S_PROBE_Y;
                else                                   state_d = S_BLOT;
            end
            S_PROBE_Y: state_d = S_CHK_Y;
            S_CHK_Y: begin
                if (w_lit && (w_y_next < c_height_lim)) state_d = S_PROBE_Y;
                else                                    state_d = S_BLOT;
            end
            S_BLOT: begin
                if (w_blot_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (!go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bounding box and blot pointer
    // ------------------------------------------------------------------
    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        box_w_d = box_w_q;
        box_h_d = box_h_q;
        bx_d    = bx_q;
        by_d    = by_q;

        case (state_q)
            S_LATCH: begin
                box_x_d = x_in;
                box_y_d = y_in;
                box_w_d = w_in_range ? 3'd1 : 3'd0;
                box_h_d = w_in_range ? 3'd1 : 3'd0;
            end
            S_CHK_X: begin
                if (w_lit) box_w_d = box_w_q + 3'd1;
            end
            S_CHK_Y: begin
                if (w_lit) box_h_d = box_h_q + 3'd1;
            end
            default: ;
        endcase

        // The pointer names the pixel written during the upcoming BLOT cycle.
        if (state_d == S_BLOT) begin
            if (state_q != S_BLOT) begin
                bx_d = box_x_d;
                by_d = box_y_d;
            end else if (w_row_end) begin
                bx_d = box_x_q;
                by_d = by_q + 3'd1;
            end else begin
                bx_d = bx_q + 3'd1;
            end
        end
    end

    // Address coordinates for the state being entered; the probe sums are
    // only used when already checked to be in range, so 3 bits suffice.
    always_comb begin
        w_addr_x = bx_d;
        w_addr_y = by_d;
        case (state_d)
            S_PROBE_X: begin
                w_addr_x = box_x_d + box_w_d;
                w_addr_y = box_y_d;
            end
            S_PROBE_Y: begin
                w_addr_x = box_x_d;
                w_addr_y = box_y_d + box_h_d;
            end
            default: ;
        endcase
    end

    mapper_addr u_addr (
        .i_x    (w_addr_x),
        .i_y    (w_addr_y),
        .o_addr (w_addr)
    );

    // ------------------------------------------------------------------
    // Output logic (registered): the address is presented during PROBE so
    // the RAM data is ready to be sampled at the end of the CHK cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_d = mem_addr_q;
        if ((state_d == S_PROBE_X) || (state_d == S_PROBE_Y) || (state_d == S_BLOT)) begin
            mem_addr_d = w_addr;
        end
        mem_wren_d = (state_d == S_BLOT);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x_q    <= 3'd0;
            box_y_q    <= 3'd0;
            box_w_q    <= 3'd0;
            box_h_q    <= 3'd0;
            bx_q       <= 3'd0;
            by_q       <= 3'd0;
            mem_addr_q <= 6'd0;
            mem_wren_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            box_x_q    <= box_x_d;
            box_y_q    <= box_y_d;
            box_w_q    <= box_w_d;
            box_h_q    <= box_h_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            mem_addr_q <= mem_addr_d;
            mem_wren_q <= mem_wren_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_wren = mem_wren_q;
    assign mem_data = '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign box_x    = box_x_q;
    assign box_y    = box_y_q;
    assign box_w    = box_w_q;
    assign box_h    = box_h_q;

endmodule
`default_nettype wire

// File: tb/tb_star_mapper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_star_mapper
// Description : Scoreboard bench for star_mapper. A 36-pixel RAM model with
//               1-cycle read latency sits on the memory port; expected writes
//               and completion boxes are queued when a start is issued and
//               checked by a monitor as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_star_mapper;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [2:0] x_in, y_in;
    logic [5:0] mem_addr;
    logic       mem_wren;
    logic [2:0] mem_data;
    logic [2:0] mem_q;
    logic       busy, done;
    logic [2:0] box_x, box_y, box_w, box_h;

    always #5 clk = ~clk;

    star_mapper #(
        .WIDTH     (6),
        .HEIGHT    (6),
        .THRESHOLD (0),
        .COL_SZ    (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .x_in     (x_in),
        .y_in     (y_in),
        .mem_addr (mem_addr),
        .mem_wren (mem_wren),
        .mem_data (mem_data),
        .mem_q    (mem_q),
        .busy     (busy),
        .done     (done),
        .box_x    (box_x),
        .box_y    (box_y),
        .box_w    (box_w),
        .box_h    (box_h)
    );

    // Image RAM model
    logic [2:0] ram [64];
    logic [2:0] pat [64];
    logic       load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) ram[i] <= pat[i];
        end else if (mem_wren) begin
            ram[mem_addr] <= mem_data;
        end
        mem_q <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    typedef struct {
        logic [2:0] x, y, w, h;
        int         cyc;
    } done_exp_t;

    int        n_cmp  = 0;
    int        n_fail = 0;
    int        wr_q[$];
    done_exp_t done_q[$];
    int        exp_a[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic      done_prev = 1'b0;
        int        e;
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (mem_wren) begin
                if (wr_q.size() == 0) begin
                    check("write_expected", wr_q.size(), 1);
                end else begin
                    e = wr_q.pop_front();
                    check("write_addr", int'(mem_addr), e);
                    check("write_data", int'(mem_data), 0);
                end
            end
            if (done && !done_prev) begin
                if (done_q.size() == 0) begin
                    check("done_expected", done_q.size(), 1);
                end else begin
                    d = done_q.pop_front();
                    check("box_x", int'(box_x), int'(d.x));
                    check("box_y", int'(box_y), int'(d.y));
                    check("box_w", int'(box_w), int'(d.w));
                    check("box_h", int'(box_h), int'(d.h));
                    check("done_cycle", cyc, d.cyc);
                end
            end
            done_prev = done;
        end
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 64; i++) pat[i] = 3'd0;
    endtask

    task automatic set_rect(input int x, input int y, input int w, input int h,
                            input logic [2:0] val);
        for (int yy = y; yy < y + h; yy++)
            for (int xx = x; xx < x + w; xx++)
                pat[yy * 6 + xx] = val;
    endtask

    task automatic load_ram();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_scn(input string tag, input logic [2:0] x, input logic [2:0] y,
                           input int n_wr, input logic [2:0] ew, input logic [2:0] eh,
                           input int lat, input int hold);
        int        waited;
        done_exp_t d;
        @(negedge clk);
        for (int i = 0; i < n_wr; i++) wr_q.push_back(exp_a[i]);
        d.x   = x;
        d.y   = y;
        d.w   = ew;
        d.h   = eh;
        d.cyc = cyc + 1 + lat;
        done_q.push_back(d);
        x_in = x;
        y_in = y;
        go   = 1'b1;
        waited = 0;
        while (!done && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!done) check({tag, "_timeout"}, int'(done), 1);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_done_held"}, int'(done), 1);
            @(negedge clk);
        end
        go = 1'b0;
        @(negedge clk);
        check({tag, "_done_clear"}, int'(done), 0);
        check({tag, "_busy_clear"}, int'(busy), 0);
        check({tag, "_writes_left"}, wr_q.size(), 0);
        check({tag, "_dones_left"}, done_q.size(), 0);
    endtask

    task automatic load_s1();
        clear_pat();
        set_rect(2, 1, 2, 3, 3'd5);
        set_rect(5, 5, 1, 1, 3'd1);
        load_ram();
    endtask

    initial begin
        int waited;
        reset = 1'b1;
        go    = 1'b0;
        x_in  = 3'd0;
        y_in  = 3'd0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({busy, done, mem_wren, mem_addr, box_x, box_y, box_w, box_h}), 0);
        reset = 1'b0;

        // 2x3 block with a stray pixel elsewhere
        load_s1();
        exp_a = '{8, 9, 14, 15, 20, 21};
        run_scn("s1", 3'd2, 3'd1, 6, 3'd2, 3'd3, 17, 3);

        // Right-edge column, stops on the bottom edge
        clear_pat();
        set_rect(5, 0, 1, 6, 3'd7);
        load_ram();
        exp_a = '{5, 11, 17, 23, 29, 35};
        run_scn("s2", 3'd5, 3'd0, 6, 3'd1, 3'd6, 17, 0);

        // Bottom row, stops on the right edge, no y probes
        clear_pat();
        set_rect(0, 5, 6, 1, 3'd2);
        load_ram();
        exp_a = '{30, 31, 32, 33, 34, 35};
        run_scn("s3", 3'd0, 3'd5, 6, 3'd6, 3'd1, 17, 0);

        // Single pixel with a diagonal neighbour that must not be picked up
        clear_pat();
        set_rect(3, 3, 1, 1, 3'd1);
        set_rect(4, 4, 1, 1, 3'd3);
        load_ram();
        exp_a = '{21, 0, 0, 0, 0, 0};
        run_scn("s4", 3'd3, 3'd3, 1, 3'd1, 3'd1, 6, 1);

        // Out-of-image start: zero-size box, no RAM traffic
        run_scn("s5", 3'd6, 3'd2, 0, 3'd0, 3'd0, 1, 0);

        // Reset in the middle of the erase
        load_s1();
        @(negedge clk);
        exp_a = '{8, 9, 14, 15, 20, 21};
        for (int i = 0; i < 6; i++) wr_q.push_back(exp_a[i]);
        x_in = 3'd2;
        y_in = 3'd1;
        go   = 1'b1;
        waited = 0;
        while (!mem_wren && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_wren) check("rst_blot_timeout", int'(mem_wren), 1);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_wren", int'(mem_wren), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        go = 1'b0;
        @(negedge clk);
        check("rst_writes_seen", wr_q.size(), 4);
        wr_q.delete();
        check("rst_px8_erased", int'(ram[8]), 0);
        check("rst_px9_erased", int'(ram[9]), 0);
        check("rst_px14_kept", int'(ram[14]), 5);
        reset = 1'b0;

        // Clean restart after the reset
        load_s1();
        exp_a = '{8, 9, 14, 15, 20, 21};
        run_scn("s6", 3'd2, 3'd1, 6, 3'd2, 3'd3, 17, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
